// File: rtl/ysyx_23060077_ex_mdu_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
// The EXU side is the master; the MDU side is the slave.
interface ysyx_23060077_ex_mdu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_src1;
  logic [DATA_WIDTH-1:0] req_src2;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output flush, req_valid, req_funct3, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  flush, req_valid, req_funct3, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ysyx_23060077_ex_mdu.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, sign fix-up in DONE.
//
//   state  | meaning
//   IDLE   | waiting for a request, req_ready high
//   CALC   | one multiply/divide iteration per cycle, r_count 0..DATA_WIDTH-1
//   DONE   | result presented on resp_data until resp_ready
module ysyx_23060077_ex_mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_23060077_ex_mdu_if.slave    mdu
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_funct3;
  logic            r_sign1;
  logic            r_sign2;
  logic            r_special;
  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_opb;

  // Request decode, evaluated against the live request bus.
  logic            w_accept;
  logic            w_is_div;
  logic            w_s1_signed;
  logic            w_s2_signed;
  logic            w_neg1;
  logic            w_neg2;
  logic [DW-1:0]   w_abs1;
  logic [DW-1:0]   w_abs2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [DW-1:0]   w_special_data;

  assign w_accept    = mdu.req_valid & (r_state == S_IDLE) & ~mdu.flush;
  assign w_is_div    = mdu.req_funct3[2];
  assign w_s1_signed = (mdu.req_funct3 != 3'b011) && (mdu.req_funct3 != 3'b101) &&
                       (mdu.req_funct3 != 3'b111);
  assign w_s2_signed = (mdu.req_funct3 == 3'b000) || (mdu.req_funct3 == 3'b001) ||
                       (mdu.req_funct3 == 3'b100) || (mdu.req_funct3 == 3'b110);
  assign w_neg1      = w_s1_signed & mdu.req_src1[DW-1];
  assign w_neg2      = w_s2_signed & mdu.req_src2[DW-1];
  assign w_abs1      = w_neg1 ? (~mdu.req_src1 + 1'b1) : mdu.req_src1;
  assign w_abs2      = w_neg2 ? (~mdu.req_src2 + 1'b1) : mdu.req_src2;
  assign w_div0      = w_is_div & (mdu.req_src2 == '0);
  // Signed overflow only exists for DIV/REM (funct3[0]==0 among the divide ops).
  assign w_ovf       = w_is_div & ~mdu.req_funct3[0] &
                       (mdu.req_src1 == {1'b1, {(DW-1){1'b0}}}) & (mdu.req_src2 == '1);
  assign w_special   = w_div0 | w_ovf;
  // For overflow src1 is already the most negative value, which is the DIV answer.
  assign w_special_data = w_div0 ? (mdu.req_funct3[1] ? mdu.req_src1 : '1)
                                 : (mdu.req_funct3[1] ? '0 : mdu.req_src1);

  // One iteration of each algorithm.
  logic [2*DW-1:0] w_mul_step;
  logic [DW:0]     w_div_hi;
  logic            w_div_borrow;
  logic [DW-1:0]   w_div_diff;
  logic [2*DW-1:0] w_div_step;

  assign w_mul_step   = r_opb[0] ? (r_acc + r_mcand) : r_acc;
  // Partial remainder after the left shift can need one bit more than DW.
  assign w_div_hi     = r_acc[2*DW-1:DW-1];
  assign w_div_borrow = w_div_hi < {1'b0, r_opb};
  assign w_div_diff   = w_div_hi[DW-1:0] - r_opb;
  assign w_div_step   = w_div_borrow ? {r_acc[2*DW-2:0], 1'b0}
                                     : {w_div_diff, r_acc[DW-2:0], 1'b1};

  // Sign fix-up of the finished magnitude result.
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_result;

  assign w_prod   = (r_sign1 ^ r_sign2) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo    = (r_sign1 ^ r_sign2) ? (~r_acc[DW-1:0] + 1'b1) : r_acc[DW-1:0];
  assign w_rem    = r_sign1 ? (~r_acc[2*DW-1:DW] + 1'b1) : r_acc[2*DW-1:DW];
  assign w_result = r_special   ? r_acc[DW-1:0] :
                    r_funct3[2] ? (r_funct3[1] ? w_rem : w_quo) :
                    (r_funct3 == 3'b000) ? w_prod[DW-1:0] : w_prod[2*DW-1:DW];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; flush overrides everything, including resp_valid.
  always_comb begin
    w_state_nxt     = r_state;
    mdu.req_ready   = (r_state == S_IDLE);
    mdu.resp_valid  = 1'b0;
    mdu.resp_data   = '0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_count == CW'(DW-1)) w_state_nxt = S_DONE;
      S_DONE: begin
        mdu.resp_valid = 1'b1;
        mdu.resp_data  = w_result;
        if (mdu.resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (mdu.flush) begin
      w_state_nxt    = S_IDLE;
      mdu.resp_valid = 1'b0;
      mdu.resp_data  = '0;
    end
  end

  // Operand latch at accept and per-cycle iteration of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_funct3  <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_special <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_opb     <= '0;
    end else if (mdu.flush) begin
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_funct3  <= mdu.req_funct3;
          r_sign1   <= w_neg1;
          r_sign2   <= w_neg2;
          r_special <= w_special;
          r_count   <= '0;
          r_opb     <= w_abs2;
          if (w_special) begin
            r_acc   <= {{DW{1'b0}}, w_special_data};
            r_mcand <= '0;
          end else if (w_is_div) begin
            r_acc   <= {{DW{1'b0}}, w_abs1};
            r_mcand <= '0;
          end else begin
            r_acc   <= '0;
            r_mcand <= {{DW{1'b0}}, w_abs1};
          end
        end
        S_CALC: begin
          r_count <= r_count + CW'(1);
          if (r_funct3[2]) begin
            r_acc <= w_div_step;
          end else begin
            r_acc   <= w_mul_step;
            r_mcand <= r_mcand << 1;
            r_opb   <= r_opb >> 1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_ex_mdu.sv
// Self-checking bench for the RV32M mul/div unit: directed table, random ops against
// an arithmetic reference, and hand-written flush/reset/backpressure sequences.
module tb_ysyx_23060077_ex_mdu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_23060077_ex_mdu_if bus ();
  ysyx_23060077_ex_mdu dut (.clk(clk), .rst_n(rst_n), .mdu(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / int arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  // Issue one op, wait for the response (bounded), consume it. Latency counts cycles after T.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat);
    @(negedge clk);
    check("req_ready_before_issue", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f;
    bus.req_src1   = a;
    bus.req_src2   = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_src1  = $urandom;
    bus.req_src2  = $urandom;
    lat  = 0;
    data = 32'hDEADBEEF;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
      if (lat > 60) begin
        check("resp_timeout", 32'd0, 32'd1);
        return;
      end
    end
    data = bus.resp_data;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int n);
    int hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.resp_valid) hits++;
    end
    check(name, hits, 32'd0);
  endtask

  vec_t        vecs[12];
  logic [31:0] data, held;
  int          lat;

  initial begin
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_src1   = '0;
    bus.req_src2   = '0;
    bus.resp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset_resp_data", bus.resp_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd4, 32'd20,       32'd0,        32'hFFFFFFFF, 1};
    vecs[5]  = '{3'd7, 32'd20,       32'd0,        32'd20,       1};
    vecs[6]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[7]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[8]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[9]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[10] = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[11] = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, data, lat);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          mode;
      f    = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (mode == 2) b = 32'($urandom_range(1, 15));
      if (mode == 3) a = 32'($urandom_range(0, 100));
      run_op(f, a, b, data, lat);
      check($sformatf("rand%0d_f%0d_data", i, f), data, ref_mdu(f, a, b));
      check($sformatf("rand%0d_lat", i), lat, ref_lat(f, a, b));
    end

    // Backpressure: result held, new requests ignored while in DONE.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd0; bus.req_src1 = 32'd5; bus.req_src2 = 32'd6;
    @(posedge clk);
    #1;
    bus.req_funct3 = 3'd5; bus.req_src1 = 32'd99; bus.req_src2 = 32'd3;
    lat = 0;
    while (!bus.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 32'd33);
    held = bus.resp_data;
    check("bp_data", held, 32'd30);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_data_stable", bus.resp_data, held);
      check("bp_req_ready_low", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("bp_idle_resp_valid", {31'b0, bus.resp_valid}, 32'd0);

    // Flush at count==10.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd5; bus.req_src1 = 32'd1000; bus.req_src2 = 32'd3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_calc_req_ready", {31'b0, bus.req_ready}, 32'd1);
    expect_quiet("flush_calc_no_resp", 40);

    // Flush in DONE beats a same-cycle response handshake.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd4; bus.req_src1 = 32'd9; bus.req_src2 = 32'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("flush_done_pre_valid", {31'b0, bus.resp_valid}, 32'd1);
    bus.flush = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    check("flush_done_valid_low", {31'b0, bus.resp_valid}, 32'd0);
    check("flush_done_data_zero", bus.resp_data, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.resp_ready = 1'b0;
    check("flush_done_idle", {31'b0, bus.req_ready}, 32'd1);
    expect_quiet("flush_done_no_resp", 5);

    // Flush beats a same-cycle accept.
    @(negedge clk);
    bus.flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd4; bus.req_src1 = 32'd9; bus.req_src2 = 32'd0;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_accept_idle", {31'b0, bus.req_ready}, 32'd1);
    expect_quiet("flush_accept_no_resp", 40);

    // Reset mid-CALC.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd1; bus.req_src1 = 32'h12345678; bus.req_src2 = 32'h9ABCDEF0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_mid_resp_data", bus.resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("rst_mid_no_resp", 40);
    run_op(3'd5, 32'd100, 32'd7, data, lat);
    check("post_rst_data", data, 32'd14);
    check("post_rst_lat", lat, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
